// File: rtl/cdb_arbiter_pkg.sv
// Shared types and defaults for the CDB write-back arbiter.
// Defines the CDB payload type, the source index enum and default sizes.
package cdb_arbiter_pkg;

    localparam int SRC_COUNT_DEFAULT   = 4;
    localparam int CDB_COUNT_DEFAULT   = 2;
    localparam int AGING_LIMIT_DEFAULT = 7;

    // Result sources in their fixed port order
    typedef enum logic [1:0] {
        SRC_ALU0 = 2'd0,
        SRC_ALU1 = 2'd1,
        SRC_LSU  = 2'd2,
        SRC_MDU  = 2'd3
    } src_idx_e;

    // One write-back result as seen by the ROB and the IQ wakeup logic
    typedef struct packed {
        logic [5:0]  rob_idx;
        logic [6:0]  prd;
        logic [31:0] data;
        logic        exception;
    } cdb_info_t;

    // Index increment with an explicit wrap, valid for any n (not only powers of two)
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Source-side handshake and CDB output bundle of the arbiter.
// master: the sources / ROB environment; slave: the arbiter itself.
interface cdb_arbiter_if #(
    parameter int SRC_COUNT = cdb_arbiter_pkg::SRC_COUNT_DEFAULT,
    parameter int CDB_COUNT = cdb_arbiter_pkg::CDB_COUNT_DEFAULT
);
    import cdb_arbiter_pkg::*;

    logic      [SRC_COUNT-1:0] src_valid_i;
    cdb_info_t [SRC_COUNT-1:0] src_info_i;
    logic      [SRC_COUNT-1:0] src_ready_o;
    logic                      cdb_ready_i;
    cdb_info_t [CDB_COUNT-1:0] cdb_o;
    logic      [CDB_COUNT-1:0] cdb_valid_o;

    modport master (
        output src_valid_i, src_info_i, cdb_ready_i,
        input  src_ready_o, cdb_o, cdb_valid_o
    );

    modport slave (
        input  src_valid_i, src_info_i, cdb_ready_i,
        output src_ready_o, cdb_o, cdb_valid_o
    );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// cdb_rr_pick: finds the first set request scanning upward from 'start'
// and wrapping modulo SRC_COUNT. Returns a one-hot hit and a found flag.
module cdb_rr_pick #(
    parameter  int SRC_COUNT = 4,
    localparam int PTR_W     = $clog2(SRC_COUNT)
) (
    input  logic [SRC_COUNT-1:0] req,
    input  logic [PTR_W-1:0]     start,
    output logic [SRC_COUNT-1:0] hit,
    output logic                 found
);

    // Wrapping priority scan; the wrap is a subtract so non-power-of-two counts work
    always_comb begin
        int idx;
        hit   = '0;
        found = 1'b0;
        for (int off = 0; off < SRC_COUNT; off++) begin
            idx = int'(start) + off;
            if (idx >= SRC_COUNT) idx = idx - SRC_COUNT;
            if (!found && req[idx]) begin
                hit[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants up to CDB_COUNT of SRC_COUNT result sources per cycle in
// round-robin order and registers the winners onto the CDB (1-cycle latency).
// Optional starvation aging is compiled in with `define CDB_ARB_AGING_EN.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int SRC_COUNT   = SRC_COUNT_DEFAULT,
    parameter int CDB_COUNT   = CDB_COUNT_DEFAULT,
    parameter int AGING_LIMIT = AGING_LIMIT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    cdb_arbiter_if.slave  bus
);

    localparam int PTR_W = $clog2(SRC_COUNT);

    if (SRC_COUNT < 2 || CDB_COUNT < 1 || CDB_COUNT > SRC_COUNT || AGING_LIMIT < 1) begin : g_bad_cfg
        $error("cdb_arbiter: illegal SRC_COUNT/CDB_COUNT/AGING_LIMIT combination");
    end

    logic      [PTR_W-1:0]     rr_ptr_q;
    logic      [PTR_W-1:0]     ptr_nxt;
    logic                      grant_en;
    logic      [SRC_COUNT-1:0] grant;
    logic      [SRC_COUNT-1:0] aged;
    logic      [SRC_COUNT-1:0] avail [CDB_COUNT+1];
    logic      [SRC_COUNT-1:0] hit   [CDB_COUNT];
    logic      [CDB_COUNT-1:0] found;
    cdb_info_t [CDB_COUNT-1:0] slot_info;
    cdb_info_t [CDB_COUNT-1:0] cdb_q;
    logic      [CDB_COUNT-1:0] cdb_valid_q;

    // Grants are only possible when the ROB accepts, no flush is pending and reset is released
    assign grant_en = bus.cdb_ready_i & ~flush & rst_n;
    assign avail[0] = grant_en ? bus.src_valid_i : '0;

    // One picker per slot; each stage sees only the requests earlier stages did not take.
    // Aged requests, when present, are served first in plain index order.
    for (genvar k = 0; k < CDB_COUNT; k++) begin : g_slot
        logic [SRC_COUNT-1:0] aged_req;
        logic [SRC_COUNT-1:0] pick_req;
        logic [PTR_W-1:0]     pick_start;

        assign aged_req   = avail[k] & aged;
        assign pick_req   = (|aged_req) ? aged_req : avail[k];
        assign pick_start = (|aged_req) ? '0 : rr_ptr_q;

        cdb_rr_pick #(.SRC_COUNT(SRC_COUNT)) u_pick (
            .req   (pick_req),
            .start (pick_start),
            .hit   (hit[k]),
            .found (found[k])
        );

        assign avail[k+1] = avail[k] & ~hit[k];
    end

    assign grant           = avail[0] & ~avail[CDB_COUNT];
    assign bus.src_ready_o = grant;
    assign bus.cdb_o       = cdb_q;
    assign bus.cdb_valid_o = cdb_valid_q;

    // Route each slot's winner payload; unused slots stay zero
    always_comb begin
        slot_info = '0;
        for (int k = 0; k < CDB_COUNT; k++) begin
            for (int i = 0; i < SRC_COUNT; i++) begin
                if (hit[k][i]) slot_info[k] = bus.src_info_i[i];
            end
        end
    end

    // Next pointer is one past the last winner in scan order; holds when nothing is granted
    always_comb begin
        ptr_nxt = rr_ptr_q;
        for (int k = 0; k < CDB_COUNT; k++) begin
            for (int i = 0; i < SRC_COUNT; i++) begin
                if (hit[k][i]) ptr_nxt = PTR_W'(wrap_inc(i, SRC_COUNT));
            end
        end
    end

    // CDB output registers and round-robin pointer; flush wins over backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= '0;
            cdb_q       <= '0;
        end else if (flush) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= '0;
            cdb_q       <= '0;
        end else if (bus.cdb_ready_i) begin
            rr_ptr_q    <= ptr_nxt;
            cdb_valid_q <= found;
            cdb_q       <= slot_info;
        end
    end

`ifdef CDB_ARB_AGING_EN
    localparam int AGE_W = $clog2(AGING_LIMIT + 1);

    logic [AGE_W-1:0] age_q [SRC_COUNT];

    // Per-source denied-cycle counters, saturating at AGING_LIMIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SRC_COUNT; i++) age_q[i] <= '0;
        end else begin
            for (int i = 0; i < SRC_COUNT; i++) begin
                if (flush || grant[i]) begin
                    age_q[i] <= '0;
                end else if (bus.cdb_ready_i && bus.src_valid_i[i] &&
                             age_q[i] != AGE_W'(AGING_LIMIT)) begin
                    age_q[i] <= age_q[i] + AGE_W'(1);
                end
            end
        end
    end

    // A source at the limit jumps ahead of the round-robin scan
    always_comb begin
        for (int i = 0; i < SRC_COUNT; i++) aged[i] = (age_q[i] == AGE_W'(AGING_LIMIT));
    end
`else
    assign aged = '0;
`endif

endmodule
